// File: rtl/ctrl_seq.sv
// ctrl_seq: SAP-1 controller/sequencer; a six-step one-hot ring runs fetch (T1-T3) and execute (T4-T6).
// Ports: clk, rst_n (async active-low), run (advance/pause), opcode (IR nibble, used from T4 on),
//        t_state (one-hot T1..T6), control word (pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
//        a_load, a_out, b_load, alu_out, alu_sub, out_load) and halt.
module ctrl_seq #(
  parameter logic [3:0] OPC_LDA = 4'b0000,
  parameter logic [3:0] OPC_ADD = 4'b0001,
  parameter logic [3:0] OPC_SUB = 4'b0010,
  parameter logic [3:0] OPC_OUT = 4'b1110,
  parameter logic [3:0] OPC_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halt
);
  typedef enum logic [5:0] {
    T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100,
    T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000
  } t_e;
  t_e st;
  // HLT needs no special state: the ring still steps T4->T5, then halt stops further rotation.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st   <= T1;
      halt <= 1'b0;
    end else if (run && !halt) begin
      st <= t_e'({st[4:0], st[5]});
      if (st == T4 && opcode == OPC_HLT) halt <= 1'b1;
    end
  assign t_state = st;
  logic en, lda, add, sub, out, mem;
  always_comb begin
    en       = rst_n & run & ~halt;
    lda      = opcode == OPC_LDA;
    add      = opcode == OPC_ADD;
    sub      = opcode == OPC_SUB;
    out      = opcode == OPC_OUT;
    mem      = lda | add | sub;
    pc_out   = en & st[0];
    pc_inc   = en & st[1];
    ir_load  = en & st[2];
    mar_load = en & (st[0] | (st[3] & mem));
    ram_out  = en & (st[2] | (st[4] & mem));
    ir_out   = en & st[3] & mem;
    a_out    = en & st[3] & out;
    out_load = en & st[3] & out;
    b_load   = en & st[4] & (add | sub);
    a_load   = en & ((st[4] & lda) | (st[5] & (add | sub)));
    alu_out  = en & st[5] & (add | sub);
    alu_sub  = en & st[5] & sub;
  end
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scoreboard bench for the SAP-1 sequencer
module tb_ctrl_seq;
  localparam logic [11:0] PCI = 12'h800, PCO = 12'h400, MAR = 12'h200, RAM = 12'h100,
                          IRL = 12'h080, IRO = 12'h040, AL  = 12'h020, AO  = 12'h010,
                          BL  = 12'h008, ALU = 12'h004, SUB = 12'h002, OUTL = 12'h001;
  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100,
                         S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;
  logic clk = 0, rst_n = 0, run = 0;
  logic [3:0] opcode = 4'h0;
  logic [5:0] t_state;
  logic pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out, b_load,
        alu_out, alu_sub, out_load, halt;
  int total = 0, bad = 0;
  logic [18:0] sb[$];
  ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .t_state(t_state),
    .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out), .b_load(b_load),
    .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load), .halt(halt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  task automatic check();
    logic [18:0] e;
    logic [11:0] c;
    e = sb.pop_front();
    c = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out, b_load,
         alu_out, alu_sub, out_load};
    chk("t_state", 32'(t_state), 32'(e[18:13]));
    chk("ctrl", 32'(c), 32'(e[12:1]));
    chk("halt", 32'(halt), 32'(e[0]));
    chk("onehot", 32'($onehot(t_state)), 32'd1);
    chk("bus", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'd1);
  endtask
  // Called at a negedge: drive, push expectation, check, then advance to the next negedge.
  task automatic cyc(input logic r, input logic [3:0] op, input logic [5:0] et,
                     input logic [11:0] ec, input logic eh);
    run = r;
    opcode = op;
    sb.push_back({et, ec, eh});
    #1 check();
    @(negedge clk);
  endtask
  task automatic fetch(input logic [3:0] op);
    cyc(1, op, S1, PCO | MAR, 0);
    cyc(1, op, S2, PCI, 0);
    cyc(1, op, S3, RAM | IRL, 0);
  endtask
  initial begin
    @(negedge clk);
    cyc(1, 4'h0, S1, 12'h000, 0);
    rst_n = 1;
    fetch(4'hF);
    cyc(1, 4'h1, S4, IRO | MAR, 0);
    cyc(1, 4'h1, S5, RAM | BL, 0);
    cyc(1, 4'h1, S6, ALU | AL, 0);
    fetch(4'hF);
    cyc(1, 4'h2, S4, IRO | MAR, 0);
    cyc(1, 4'h2, S5, RAM | BL, 0);
    cyc(1, 4'h2, S6, ALU | AL | SUB, 0);
    fetch(4'h7);
    cyc(1, 4'h0, S4, IRO | MAR, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'h0, S5, 12'h000, 0);
    cyc(1, 4'h0, S5, RAM | AL, 0);
    cyc(1, 4'h0, S6, 12'h000, 0);
    fetch(4'hE);
    cyc(1, 4'hE, S4, AO | OUTL, 0);
    cyc(1, 4'hE, S5, 12'h000, 0);
    cyc(1, 4'hE, S6, 12'h000, 0);
    fetch(4'h1);
    cyc(1, 4'h7, S4, 12'h000, 0);
    cyc(1, 4'h7, S5, 12'h000, 0);
    cyc(1, 4'h7, S6, 12'h000, 0);
    fetch(4'h2);
    cyc(1, 4'h0, S4, IRO | MAR, 0);
    run = 1;
    #2 rst_n = 0;
    sb.push_back({S1, 12'h000, 1'b0});
    #1 check();
    @(negedge clk);
    rst_n = 1;
    fetch(4'h0);
    cyc(1, 4'hF, S4, 12'h000, 0);
    for (int i = 0; i < 20; i++) cyc(1'(i % 3 != 0), 4'($urandom_range(0, 15)), S5, 12'h000, 1);
    rst_n = 0;
    sb.push_back({S1, 12'h000, 1'b0});
    #1 check();
    @(negedge clk);
    rst_n = 1;
    fetch(4'h1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
